// File: rtl/four_req_rr_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin arbiter.
package four_req_rr_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam logic [1:0] REQ_A = 2'd0;
  localparam logic [1:0] REQ_B = 2'd1;
  localparam logic [1:0] REQ_C = 2'd2;
  localparam logic [1:0] REQ_D = 2'd3;

  // One-hot vector for requester index i.
  function automatic logic [3:0] onehot4(input logic [1:0] i);
    return 4'b0001 << i;
  endfunction

endpackage

// File: rtl/four_req_rr_arbiter_rr_pick4.sv
// Combinational round-robin picker: first eligible request at or after ptr,
// wrapping modulo 4. mask removes requesters from consideration.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic [3:0] mask,
  output logic       found,
  output logic [1:0] idx
);

  logic [3:0] elig;
  logic [1:0] cand;

  assign elig = req & ~mask;

  // Walk offsets from farthest to nearest so the nearest eligible one wins.
  always_comb begin
    found = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int i = 3; i >= 0; i--) begin
      cand = ptr + 2'(i);
      if (elig[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/four_req_rr_arbiter.sv
// Four-requester round-robin arbiter with registered one-hot grant and a
// bounded hold time. The owner keeps the grant while requesting, but is
// forced off after HOLD_MAX cycles if anyone else is waiting.
module four_req_rr_arbiter
  import four_req_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_id,
  output logic       busy,
  output logic       any_req,
  output logic       timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  arb_state_t       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       gnt_id_q, gnt_id_d;
  logic             busy_q, busy_d;
  logic             timeout_q, timeout_d;

  logic [3:0] pick_mask;
  logic       pick_found;
  logic [1:0] pick_idx;
  logic       own_req;
  logic       hold_last;
  logic       load;

  assign any_req   = |req;
  assign own_req   = req[gnt_id_q];
  assign hold_last = (cnt_q == HOLD_LAST);

  // While granted the owner is always excluded: on release its bit is already
  // clear, and on a forced rotation it must not win again.
  assign pick_mask = (state_q == ST_GRANT) ? onehot4(gnt_id_q) : 4'b0000;

  rr_pick4 u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .mask  (pick_mask),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Next-state and output decode; a new grant is applied through 'load'.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    busy_d    = busy_q;
    timeout_d = 1'b0;
    load      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found) load = 1'b1;
      end
      ST_GRANT: begin
        if (!own_req) begin
          if (pick_found) begin
            load = 1'b1;
          end else begin
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (!hold_last) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (pick_found) begin
          load      = 1'b1;
          timeout_d = 1'b1;
        end else begin
          // Lone holder: restart the hold window, no rotation.
          cnt_d = '0;
        end
      end
      default: begin
        gnt_d   = 4'b0000;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (load) begin
      gnt_d    = onehot4(pick_idx);
      gnt_id_d = pick_idx;
      busy_d   = 1'b1;
      ptr_d    = pick_idx + 2'd1;
      cnt_d    = '0;
      state_d  = ST_GRANT;
    end
  end

  // State, pointer, counter and output registers; reset clears grant at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= REQ_A;
      cnt_q     <= '0;
      gnt_q     <= 4'b0000;
      gnt_id_q  <= REQ_A;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = gnt_id_q;
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_four_req_rr_arbiter.sv
// Bench for four_req_rr_arbiter: behavioural model + per-cycle compare,
// directed scenarios with literal expectations, then randomized requests.
module tb_four_req_rr_arbiter;

  localparam int HOLD_MAX = 8;
  localparam int WAIT_LIM = 3 * HOLD_MAX + 2;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       any_req;
  logic       timeout;

  int total;
  int bad;

  four_req_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .any_req (any_req),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_busy;
  int m_own;
  int m_ptr;
  int m_cnt;
  bit m_to;
  int wt[4];

  // First requester at or after p (mod 4), skipping excl; -1 if none.
  function automatic int mpick(input logic [3:0] r, input int p, input int excl);
    for (int off = 0; off < 4; off++) begin
      int j;
      j = (p + off) % 4;
      if (r[j] && j != excl) return j;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_own  <= 0;
      m_ptr  <= 0;
      m_cnt  <= 0;
      m_to   <= 1'b0;
    end else begin : upd
      int own, ptr, cnt, w;
      bit b, to;
      own = m_own; ptr = m_ptr; cnt = m_cnt; b = m_busy; to = 1'b0; w = -1;
      if (!b)                  w = mpick(req, ptr, -1);
      else if (!req[own]) begin
        w = mpick(req, ptr, -1);
        if (w < 0) b = 1'b0;
      end
      else if (cnt < HOLD_MAX - 1) cnt++;
      else begin
        w = mpick(req, ptr, own);
        if (w >= 0) to = 1'b1; else cnt = 0;
      end
      if (w >= 0) begin
        b = 1'b1; own = w; ptr = (w + 1) % 4; cnt = 0;
      end
      m_busy <= b; m_own <= own; m_ptr <= ptr; m_cnt <= cnt; m_to <= to;
    end
  end

  // Per-cycle compare against the model, plus the starvation bound.
  always @(negedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) wt[i] = 0;
    end else begin : cmp
      logic [3:0] eg;
      eg = 4'b0000;
      if (m_busy) eg[m_own] = 1'b1;
      chk("m_gnt", gnt, eg);
      chk("m_busy", busy, m_busy);
      chk("m_timeout", timeout, m_to);
      chk("m_any_req", any_req, |req);
      if (m_busy) chk("m_gnt_id", gnt_id, m_own);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !gnt[i]) wt[i]++; else wt[i] = 0;
        chk("wait_bound", wt[i] <= WAIT_LIM, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic rst_pulse;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    req   = 4'b1111;

    // reset and idle
    repeat (3) tick();
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    req   = 4'b0000;
    rst_n = 1'b1;
    #1 chk("idle_any_req", any_req, 0);
    tick();
    chk("idle_gnt", gnt, 4'b0000);
    req = 4'b0100;
    #1 chk("comb_any_req", any_req, 1);

    // single request, one-cycle latency
    tick();
    chk("single_gnt", gnt, 4'b0100);
    chk("single_id", gnt_id, 2);
    chk("single_busy", busy, 1);
    req = 4'b0000;
    tick();
    chk("single_rel_gnt", gnt, 4'b0000);
    chk("single_rel_busy", busy, 0);

    // round-robin fairness a,b,c,d,a with no idle gap
    rst_pulse();
    req = 4'b1111;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] oh;
      oh = 4'b0001 << k;
      chk("rr_first", gnt, oh);
      tick();
      chk("rr_second", gnt, oh);
      req = 4'b1111 & ~oh;
      tick();
      req = 4'b1111;
    end
    chk("rr_wrap_a", gnt, 4'b0001);

    // forced rotation after HOLD_MAX cycles
    rst_pulse();
    req = 4'b0011;
    tick();
    chk("to_a0", gnt, 4'b0001);
    for (int i = 1; i < HOLD_MAX; i++) begin
      tick();
      chk("to_a_hold", gnt, 4'b0001);
      chk("to_a_nopulse", timeout, 0);
    end
    tick();
    chk("to_b_gnt", gnt, 4'b0010);
    chk("to_b_pulse", timeout, 1);
    for (int i = 1; i < HOLD_MAX; i++) begin
      tick();
      chk("to_b_hold", gnt, 4'b0010);
      chk("to_b_nopulse", timeout, 0);
    end
    tick();
    chk("to_back_a", gnt, 4'b0001);
    chk("to_back_pulse", timeout, 1);

    // lone holder never times out
    req = 4'b1000;
    for (int i = 0; i < 30; i++) begin
      tick();
      chk("lone_gnt", gnt, 4'b1000);
      chk("lone_timeout", timeout, 0);
    end

    // reset mid-grant clears immediately; pointer restarts at a
    req = 4'b0010;
    tick();
    chk("mid_pre_gnt", gnt, 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_gnt", gnt, 4'b0000);
    chk("mid_rst_busy", busy, 0);
    req = 4'b0011;
    #1 rst_n = 1'b1;
    tick();
    chk("mid_after_gnt", gnt, 4'b0001);
    chk("mid_after_id", gnt_id, 0);

    // randomized traffic, mostly slow-changing so holds and timeouts occur
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
      else if ($urandom_range(0, 15) == 0) req[$urandom_range(0, 3)] = ~req[$urandom_range(0, 3)];
      if (n % 700 == 350) rst_pulse();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
